uart_rx: RTL



---
 rtl/uart_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx_i passes a 2-flop synchronizer, then a bit timer schedules
// mid-bit samples for the start, data and stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_s1_q, rx_s1_d;
  logic          rx_s2_q, rx_s2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;

  // Next-state, datapath and output computation; every sample edge reloads the timer.
  always_comb begin
    rx_s1_d = rx_i;
    rx_s2_d = rx_s1_q;
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_s2_q == 1'b0) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          bit_d   = 3'd0;
          if (rx_s2_q == 1'b1) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s2_q == 1'b1) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start can be seen.
        timer_d = '0;
        if (rx_s2_q == 1'b1) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // All state, including the synchronizer, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      timer_q <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign d_o         = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;

endmodule
